// File: rtl/tt_response_checker_pkg.sv
// Shared types and default sizing for the truth-table response checker.
// The state encoding and the default majority-function configuration live here.
package tt_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } tt_state_e;

  localparam int TT_N_IN    = 3;
  localparam int TT_DEPTH   = 2 ** TT_N_IN;
  localparam int CNT_W      = TT_N_IN + 1;
  localparam int TT_TIMEOUT = 16;

  // 3-input majority: f=1 when at least two inputs are high.
  localparam logic [TT_DEPTH-1:0] TT_EXPECTED = 8'hE8;

endpackage

// File: rtl/tt_response_checker_if.sv
// Sample/result bundle between a stimulus source (master) and the checker (slave).
// Result widths follow the input width, so both sides must use the same N_IN.
interface tt_response_checker_if #(
  parameter int N_IN = 3
);

  logic                  start;
  logic                  sample_valid;
  logic [N_IN-1:0]       sample_in;
  logic                  sample_f;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  timeout;
  logic                  conflict;
  logic [(2**N_IN)-1:0]  table_out;
  logic [(2**N_IN)-1:0]  covered;
  logic [N_IN:0]         mismatch_cnt;
  logic [N_IN-1:0]       first_err_idx;

  modport master (
    output start, sample_valid, sample_in, sample_f,
    input  busy, done, pass, timeout, conflict,
    input  table_out, covered, mismatch_cnt, first_err_idx
  );

  modport slave (
    input  start, sample_valid, sample_in, sample_f,
    output busy, done, pass, timeout, conflict,
    output table_out, covered, mismatch_cnt, first_err_idx
  );

endinterface

// File: rtl/tt_response_checker_idle_timer.sv
// Saturating idle counter: counts ticks since the last clear and flags when the
// count has reached TIMEOUT-1, i.e. the next idle tick would exceed the budget.
module tt_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear dominates, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (tick && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/tt_response_checker.sv
// Records observed truth-table responses, tracks index coverage, counts
// mismatches against EXPECTED and reports done/pass on full coverage or idle timeout.
module tt_response_checker
  import tt_check_pkg::*;
#(
  parameter int                    N_IN     = TT_N_IN,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = TT_EXPECTED,
  parameter int                    TIMEOUT  = TT_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst_n,
  tt_response_checker_if.slave bus
);

  localparam int DEPTH = 2 ** N_IN;
  localparam int CW    = N_IN + 1;

  tt_state_e         state_q, state_d;
  logic [DEPTH-1:0]  table_q, table_d;
  logic [DEPTH-1:0]  covered_q, covered_d;
  logic [CW-1:0]     mis_cnt_q, mis_cnt_d;
  logic [N_IN-1:0]   first_err_q, first_err_d;
  logic              conflict_q, conflict_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [DEPTH-1:0]  sel_s;
  logic              in_collect_s;
  logic              expired_s;
  logic              timer_clear_s;
  logic              timer_tick_s;

  assign sel_s        = {{(DEPTH-1){1'b0}}, 1'b1} << bus.sample_in;
  assign in_collect_s = (state_q == ST_COLLECT);

  // Any valid sample while collecting restarts the idle window, duplicates included.
  assign timer_clear_s = bus.start | ~in_collect_s | bus.sample_valid;
  assign timer_tick_s  = in_collect_s & ~bus.sample_valid & ~bus.start;

  tt_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear_s),
    .tick    (timer_tick_s),
    .expired (expired_s)
  );

  // Next-state and result update; start has priority over any sample.
  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    covered_d   = covered_q;
    mis_cnt_d   = mis_cnt_q;
    first_err_d = first_err_q;
    conflict_d  = conflict_q;
    timeout_d   = timeout_q;
    if (bus.start) begin
      state_d     = ST_COLLECT;
      table_d     = {DEPTH{1'b0}};
      covered_d   = {DEPTH{1'b0}};
      mis_cnt_d   = {CW{1'b0}};
      first_err_d = {N_IN{1'b0}};
      conflict_d  = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_COLLECT: begin
          if (bus.sample_valid) begin
            if (covered_q[bus.sample_in] == 1'b0) begin
              table_d[bus.sample_in] = bus.sample_f;
              covered_d              = covered_q | sel_s;
              if (bus.sample_f != EXPECTED[bus.sample_in]) begin
                mis_cnt_d = mis_cnt_q + CW'(1);
                if (mis_cnt_q == {CW{1'b0}}) begin
                  first_err_d = bus.sample_in;
                end else begin
                  first_err_d = first_err_q;
                end
              end else begin
                mis_cnt_d = mis_cnt_q;
              end
              if ((covered_q | sel_s) == {DEPTH{1'b1}}) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_COLLECT;
              end
            end else if (table_q[bus.sample_in] != bus.sample_f) begin
              conflict_d = 1'b1;
            end else begin
              conflict_d = conflict_q;
            end
          end else if (expired_s) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // Status flags are derived from the next state so they line up with the results.
    busy_d = (state_d == ST_COLLECT);
    done_d = (state_d == ST_DONE);
    pass_d = done_d & (mis_cnt_d == {CW{1'b0}}) & ~conflict_d & ~timeout_d;
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      table_q     <= {DEPTH{1'b0}};
      covered_q   <= {DEPTH{1'b0}};
      mis_cnt_q   <= {CW{1'b0}};
      first_err_q <= {N_IN{1'b0}};
      conflict_q  <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      covered_q   <= covered_d;
      mis_cnt_q   <= mis_cnt_d;
      first_err_q <= first_err_d;
      conflict_q  <= conflict_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.timeout       = timeout_q;
  assign bus.conflict      = conflict_q;
  assign bus.table_out     = table_q;
  assign bus.covered       = covered_q;
  assign bus.mismatch_cnt  = mis_cnt_q;
  assign bus.first_err_idx = first_err_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: directed scenarios plus randomized traffic,
// every cycle compared against a table/array reference model.
module tb_tt_response_checker;
  import tt_check_pkg::*;

  localparam int              NI  = 3;
  localparam int              D   = TT_DEPTH;
  localparam int              TO  = 16;
  localparam logic [D-1:0]    EXP = 8'hE8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_response_checker_if #(.N_IN(NI)) bus ();

  tt_response_checker #(
    .N_IN     (NI),
    .EXPECTED (EXP),
    .TIMEOUT  (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = idle, 1 = collecting, 2 = finished.
  int m_phase = 0;
  bit m_seen [D];
  bit m_obs  [D];
  int m_nmis, m_first, m_edge, m_last;
  bit m_conf, m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_seen[i] = 1'b0;
      m_obs[i]  = 1'b0;
    end
    m_nmis  = 0;
    m_first = 0;
    m_conf  = 1'b0;
    m_to    = 1'b0;
  endtask

  function automatic int seen_count();
    int n = 0;
    for (int i = 0; i < D; i++) n += m_seen[i];
    return n;
  endfunction

  function automatic logic [D-1:0] pack(input bit use_obs);
    logic [D-1:0] v = '0;
    for (int i = 0; i < D; i++) v[i] = use_obs ? (m_seen[i] & m_obs[i]) : m_seen[i];
    return v;
  endfunction

  task automatic model_edge(input bit rn, input bit st, input bit v, input int idx, input bit f);
    m_edge++;
    if (!rn) begin
      m_phase = 0;
      model_clear();
    end else if (st) begin
      m_phase = 1;
      model_clear();
      m_last = m_edge;
    end else if (m_phase == 1) begin
      if (v) begin
        m_last = m_edge;
        if (!m_seen[idx]) begin
          m_seen[idx] = 1'b1;
          m_obs[idx]  = f;
          if (f != EXP[idx]) begin
            if (m_nmis == 0) m_first = idx;
            m_nmis++;
          end
          if (seen_count() == D) m_phase = 2;
        end else if (m_obs[idx] != f) begin
          m_conf = 1'b1;
        end
      end else if (m_edge - m_last == TO) begin
        m_phase = 2;
        m_to    = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    bit m_done;
    m_done = (m_phase == 2);
    check_eq({tag, ".busy"},     bus.busy,      (m_phase == 1));
    check_eq({tag, ".done"},     bus.done,      m_done);
    check_eq({tag, ".pass"},     bus.pass,      m_done && m_nmis == 0 && !m_conf && !m_to);
    check_eq({tag, ".timeout"},  bus.timeout,   m_to);
    check_eq({tag, ".conflict"}, bus.conflict,  m_conf);
    check_eq({tag, ".table"},    bus.table_out, pack(1'b1));
    check_eq({tag, ".covered"},  bus.covered,   pack(1'b0));
    check_eq({tag, ".mis_cnt"},  bus.mismatch_cnt, m_nmis);
    if (m_nmis > 0) check_eq({tag, ".first_err"}, bus.first_err_idx, m_first);
  endtask

  task automatic step(input bit rn, input bit st, input bit v, input int idx, input bit f,
                      input string tag);
    logic [31:0] iv;
    iv             = idx;
    rst_n          = rn;
    bus.start      = st;
    bus.sample_valid = v;
    bus.sample_in  = iv[NI-1:0];
    bus.sample_f   = f;
    @(posedge clk);
    model_edge(rn, st, v, idx, f);
    #1;
    compare_all(tag);
  endtask

  task automatic go(input bit st, input bit v, input int idx, input bit f, input string tag);
    step(1'b1, st, v, idx, f, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) go(1'b0, 1'b0, $urandom_range(0, D - 1), $urandom_range(0, 1), tag);
  endtask

  function automatic bit outputs_zero();
    return {bus.busy, bus.done, bus.pass, bus.timeout, bus.conflict, bus.table_out,
            bus.covered, bus.mismatch_cnt, bus.first_err_idx} == '0;
  endfunction

  initial begin
    m_edge = 0;
    m_last = 0;
    model_clear();

    step(1'b0, 1'b0, 1'b0, 0, 1'b0, "rst");
    step(1'b0, 1'b1, 1'b1, 3, 1'b1, "rst");
    check_eq("rst.all_zero", outputs_zero(), 1'b1);

    // Scenario 1: full majority table back-to-back.
    go(1'b1, 1'b0, 0, 1'b0, "s1");
    for (int i = 0; i < D; i++) begin
      go(1'b0, 1'b1, i, EXP[i], "s1");
      if (i == D - 2) check_eq("s1.not_done_before_last", bus.done, 1'b0);
    end
    check_eq("s1.done", bus.done, 1'b1);
    check_eq("s1.busy", bus.busy, 1'b0);
    check_eq("s1.table", bus.table_out, 8'hE8);
    check_eq("s1.covered", bus.covered, 8'hFF);
    check_eq("s1.mis_cnt", bus.mismatch_cnt, 4'd0);
    check_eq("s1.pass", bus.pass, 1'b1);

    // Scenario 2: index 5 answered wrongly.
    go(1'b1, 1'b0, 0, 1'b0, "s2");
    for (int i = 0; i < D; i++) go(1'b0, 1'b1, i, (i == 5) ? 1'b0 : EXP[i], "s2");
    check_eq("s2.table", bus.table_out, 8'hC8);
    check_eq("s2.mis_cnt", bus.mismatch_cnt, 4'd1);
    check_eq("s2.first_err", bus.first_err_idx, 3'd5);
    check_eq("s2.pass", bus.pass, 1'b0);
    check_eq("s2.done", bus.done, 1'b1);

    // Scenario 3: descending with gaps; consistent then conflicting duplicates of index 2.
    for (int run = 0; run < 2; run++) begin
      go(1'b1, 1'b0, 0, 1'b0, "s3");
      for (int i = D - 1; i >= 0; i--) begin
        go(1'b0, 1'b1, i, EXP[i], "s3");
        idle(3, "s3");
        if (i == 2) begin
          for (int r = 0; r <= run; r++) begin
            go(1'b0, 1'b1, 2, (run == 0) ? 1'b0 : 1'b1, "s3");
            idle(3, "s3");
          end
        end
      end
      check_eq("s3.done", bus.done, 1'b1);
      check_eq("s3.conflict", bus.conflict, (run == 1));
      check_eq("s3.pass", bus.pass, (run == 0));
      check_eq("s3.table", bus.table_out, 8'hE8);
    end

    // Scenario 4: idle timeout after partial coverage.
    go(1'b1, 1'b0, 0, 1'b0, "s4");
    for (int i = 0; i < 6; i++) go(1'b0, 1'b1, i, EXP[i], "s4");
    for (int k = 1; k <= 20; k++) begin
      go(1'b0, 1'b0, 7, 1'b1, "s4");
      if (k == TO - 1) check_eq("s4.done_early", bus.done, 1'b0);
      if (k == TO) begin
        check_eq("s4.done", bus.done, 1'b1);
        check_eq("s4.timeout", bus.timeout, 1'b1);
        check_eq("s4.covered", bus.covered, 8'h3F);
        check_eq("s4.pass", bus.pass, 1'b0);
      end
    end

    // Scenario 5: reset mid-collection discards everything.
    go(1'b1, 1'b0, 0, 1'b0, "s5");
    for (int i = 0; i < 4; i++) go(1'b0, 1'b1, i, ~EXP[i], "s5");
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, "s5");
    check_eq("s5.all_zero", outputs_zero(), 1'b1);
    go(1'b0, 1'b1, 4, 1'b1, "s5");
    go(1'b0, 1'b1, 5, 1'b1, "s5");
    check_eq("s5.ignored", bus.covered, 8'h00);
    check_eq("s5.idle", bus.busy, 1'b0);

    // Scenario 6: start wins over a same-cycle sample.
    go(1'b1, 1'b1, 3, 1'b1, "s6");
    check_eq("s6.covered", bus.covered, 8'h00);
    check_eq("s6.busy", bus.busy, 1'b1);
    go(1'b0, 1'b1, 3, 1'b1, "s6");
    check_eq("s6.covered_after", bus.covered, 8'h08);
    check_eq("s6.table_after", bus.table_out, 8'h08);

    // Randomized traffic in segments with varying sample density.
    for (int seg = 0; seg < 120; seg++) begin
      int p;
      int len;
      p   = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 50 : 90);
      len = $urandom_range(5, 40);
      for (int c = 0; c < len; c++) begin
        bit rn;
        bit st;
        bit v;
        int idx;
        bit f;
        rn  = ($urandom_range(0, 399) != 0);
        st  = ($urandom_range(0, 79) == 0) || (m_phase != 1 && $urandom_range(0, 7) == 0);
        v   = ($urandom_range(0, 99) < p);
        idx = $urandom_range(0, D - 1);
        f   = ($urandom_range(0, 9) == 0) ? ~EXP[idx] : EXP[idx];
        step(rn, st, v, idx, f, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
Synthesizable response-side checker for small combinational blocks under exhaustive truth-table test. A stimulus source drives the input vector into the block under test; this checker receives each applied input vector and the resulting output, one per strobe. It records the observed truth table, tracks coverage and compares against an expected table. When every input combination has been seen, or the idle timeout expires, it reports done and pass/fail.

Parameters:
N_IN, 3, width of the input vector; table depth is 2**N_IN.
EXPECTED, 8'hE8, expected truth table; bit i is the expected f for input i. Default is the 3-input majority function.
TIMEOUT, 16, maximum idle cycles in COLLECT between accepted samples before aborting.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst_n  in  1  reset; synchronous, active-low.
start  in  1  one-cycle pulse: clear all results and arm collection.
sample_valid  in  1  sample_in and sample_f are valid this cycle.
sample_in  in  N_IN  input vector applied to the block under test.
sample_f  in  1  observed output for sample_in.
busy  out  1  high in COLLECT.
done  out  1  high in DONE.
pass  out  1  meaningful only when done=1.
timeout  out  1  sticky; set when collection ended by idle timeout.
conflict  out  1  sticky; set when the same index was seen with a differing f.
table_out  out  2**N_IN  observed f per index; holds the first-seen value.
covered  out  2**N_IN  bit i set once index i has been seen.
mismatch_cnt  out  N_IN+1  number of indices whose first f differs from EXPECTED.
first_err_idx  out  N_IN  index of the first mismatch; valid when mismatch_cnt>0.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE. All outputs 0, idle counter 0. Reset mid-collection discards all results.
- IDLE: samples are ignored. start -> COLLECT on the next cycle, clearing table_out, covered, counters and flags.
- COLLECT, sample_valid=1 with covered[idx]=0:
  - table_out[idx]<=sample_f; covered[idx]<=1.
  - If sample_f!=EXPECTED[idx], mismatch_cnt increments. If it was 0, first_err_idx<=idx.
- COLLECT, sample_valid=1 with covered[idx]=1:
  - Table and counters are unchanged.
  - If sample_f!=table_out[idx], conflict<=1.
- Latency: a sample accepted at edge k is visible on the outputs after edge k.
- If the sample at edge k makes covered all-ones, state is DONE after edge k: done=1, busy=0.
- Idle counter: resets to 0 on each accepted sample and on entry to COLLECT; otherwise increments. When it reaches TIMEOUT-1 with no sample that cycle, state goes to DONE and timeout<=1.
- pass = done & (mismatch_cnt==0) & ~conflict & ~timeout. It is registered and valid in the same cycle as done.
- DONE: all results hold and samples are ignored. start -> COLLECT with results cleared.
- start during COLLECT restarts collection (results cleared).
- start and sample_valid in the same cycle: start wins and the sample is dropped.
- Widths: mismatch_cnt holds 0..2**N_IN without wrap; the idle counter is $clog2(TIMEOUT) bits and saturates.

Decomposition:
- Package tt_check_pkg: state enum {IDLE, COLLECT, DONE}; localparams TT_DEPTH=2**N_IN, CNT_W=N_IN+1.
- One sub-module tt_idle_timer: clear/tick inputs and an expired output. Instantiated once.

Test Plan:
1. Reset, start, then indices 0..7 back-to-back with majority values -> done one cycle after index 7; table_out=8'hE8, covered=8'hFF, mismatch_cnt=0, pass=1.
2. As scenario 1 but index 5 with f=0 -> table_out=8'hC8, mismatch_cnt=1, first_err_idx=5, pass=0.
3. Indices 7..0 with 3 idle cycles between samples; extra index 2 with f=0 -> pass=1, conflict=0. Then restart, repeat, and send index 2 with f=1 twice after its first sample -> conflict=1, pass=0.
4. Start, indices 0..5 only, then idle -> TIMEOUT cycles after the last sample: done=1, timeout=1, covered=8'h3F, pass=0.
5. Start, 4 samples, rst_n=0 for one cycle -> all outputs 0, state IDLE; further samples ignored until start.
6. start with sample_valid=1, sample_in=3 in the same cycle -> covered=8'h00, busy=1. A later sample at index 3 is recorded normally.
